lhn_itrace_streamer_v: RTL and testbench



---
 rtl/lhn_itrace_streamer_v_if.sv | 33 +++
 rtl/lhn_itrace_streamer_v.sv | 165 ++++++++++++++++
 tb/tb_lhn_itrace_streamer_v.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lhn_itrace_streamer_v_if.sv
// Byte-stream trace bundle: decoder string strobe in, serialized ASCII bytes out.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the debug sink stalls the byte stream; ICis_valid is never stalled.
// Ports/signals:
//   ICis[95:0]  ASCII string, byte 11 (bits 95:88) first
//   ICis_valid  one-cycle capture strobe
//   out_data    current output byte
//   out_valid   out_data valid
//   out_ready   sink accepts byte on out_valid & out_ready
// Modports: master = streamer side, slave = decoder/sink side.
interface lhn_itrace_streamer_v_if;
   logic [95:0] ICis;
   logic        ICis_valid;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;

   modport master (
      input  ICis,
      input  ICis_valid,
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      output ICis,
      output ICis_valid,
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/lhn_itrace_streamer_v.sv
// Instruction trace streamer: buffers 96-bit ASCII strings and emits them byte-serially, leading NULs dropped.
// Latency: strobe at cycle N -> first non-zero byte valid at N+2 (+1 cycle per suppressed leading NUL).
// Backpressure: out_ready stalls the serializer only; a full FIFO drops strings and counts them.
// Ports:
//   Clock_pin      rising-edge clock
//   Reset_pin      synchronous active-high reset
//   trace          lhn_itrace_streamer_v_if.master (ICis/ICis_valid in, out_data/out_valid/out_ready)
//   busy           FIFO non-empty or serializer active
//   overflow       sticky, set on first dropped string
//   drop_cnt       saturating count of dropped strings
// Build option: define TRACE_CRLF_EN to terminate every string with 0x0D 0x0A.
module lhn_itrace_streamer_v #(
   parameter int DEPTH  = 8,
   parameter int DROP_W = 8
) (
   input  logic                      Clock_pin,
   input  logic                      Reset_pin,
   lhn_itrace_streamer_v_if.master   trace,
   output logic                      busy,
   output logic                      overflow,
   output logic [DROP_W-1:0]         drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]       CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]       CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
   localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

`ifdef TRACE_CRLF_EN
   typedef enum logic [2:0] {IDLE, LOAD, SEND, CR, LF} state_t;
   localparam state_t DONE_STATE = CR;
`else
   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
   localparam state_t DONE_STATE = IDLE;
`endif

   // string FIFO
   logic [95:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   // serializer
   state_t        state, state_nxt;
   logic [95:0]   sh, sh_nxt;
   logic [3:0]    idx, idx_nxt;
   logic          sent, sent_nxt;
   logic          obyte_valid, obyte_valid_nxt;
   logic [7:0]    obyte_data, obyte_data_nxt;

   logic          push, pop, drop, hs, skip;

   // a pop in the same cycle frees a slot, so a full FIFO still accepts
   assign pop  = (state == LOAD);
   assign push = trace.ICis_valid && ((count != CNT_FULL) || pop);
   assign drop = trace.ICis_valid && !push;

   assign hs   = obyte_valid && trace.out_ready;
   // leading NULs are skipped until the first non-zero byte of this string has gone out
   assign skip = (state == SEND) && !sent && (sh[95:88] == 8'h00);

   assign busy            = (count != '0) || (state != IDLE);
   assign trace.out_valid = obyte_valid;
   assign trace.out_data  = obyte_data;

   always_comb begin
      state_nxt = state;
      sh_nxt    = sh;
      idx_nxt   = idx;
      sent_nxt  = sent;
      case (state)
         IDLE: begin
            // including a same-cycle push gives LOAD one cycle after the strobe
            if ((count != '0) || push) state_nxt = LOAD;
         end
         LOAD: begin
            sh_nxt    = mem[rd_ptr];
            idx_nxt   = 4'd11;
            sent_nxt  = 1'b0;
            state_nxt = SEND;
         end
         SEND: begin
            if (skip || hs) begin
               sh_nxt  = {sh[87:0], 8'h00};
               idx_nxt = idx - 4'd1;
               if (hs) sent_nxt = 1'b1;
               if (idx == 4'd0) state_nxt = DONE_STATE;
            end
         end
`ifdef TRACE_CRLF_EN
         CR: begin
            if (hs) state_nxt = LF;
         end
         LF: begin
            if (hs) state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase

      // outputs are registered: derive next cycle's byte from next-cycle state
      obyte_valid_nxt = 1'b0;
      obyte_data_nxt  = 8'h00;
      case (state_nxt)
         SEND: begin
            if (sent_nxt || (sh_nxt[95:88] != 8'h00)) begin
               obyte_valid_nxt = 1'b1;
               obyte_data_nxt  = sh_nxt[95:88];
            end
         end
`ifdef TRACE_CRLF_EN
         CR: begin
            obyte_valid_nxt = 1'b1;
            obyte_data_nxt  = 8'h0D;
         end
         LF: begin
            obyte_valid_nxt = 1'b1;
            obyte_data_nxt  = 8'h0A;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge Clock_pin) begin
      if (Reset_pin) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         sh          <= '0;
         idx         <= '0;
         sent        <= 1'b0;
         obyte_valid <= 1'b0;
         obyte_data  <= 8'h00;
         overflow    <= 1'b0;
         drop_cnt    <= '0;
      end else begin
         state       <= state_nxt;
         sh          <= sh_nxt;
         idx         <= idx_nxt;
         sent        <= sent_nxt;
         obyte_valid <= obyte_valid_nxt;
         obyte_data  <= obyte_data_nxt;
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: ;
         endcase
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_ONE;
         end
      end
   end

   // storage needs no reset: pointers and count define what is valid
   always_ff @(posedge Clock_pin) begin
      if (push) mem[wr_ptr] <= trace.ICis;
   end

endmodule

// File: tb/tb_lhn_itrace_streamer_v.sv
// Bench for lhn_itrace_streamer_v: expected bytes queued at stimulus time, a monitor pops on each handshake.
// Latency: checks first-byte and drain timing against the string rules.
// Backpressure: random and directed out_ready stalls; FIFO overflow and drop saturation.
module tb_lhn_itrace_streamer_v;

   localparam int DEPTH  = 8;
   localparam int DROP_W = 8;
`ifdef TRACE_CRLF_EN
   localparam int TERM = 2;
`else
   localparam int TERM = 0;
`endif

   typedef struct packed {
      logic [7:0] b;
      logic       last;
   } exp_t;

   logic              Clock_pin = 1'b0;
   logic              Reset_pin;
   logic              busy;
   logic              overflow;
   logic [DROP_W-1:0] drop_cnt;

   lhn_itrace_streamer_v_if trace ();

   lhn_itrace_streamer_v #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
      .Clock_pin (Clock_pin),
      .Reset_pin (Reset_pin),
      .trace     (trace),
      .busy      (busy),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
   );

   always #5 Clock_pin = ~Clock_pin;

   int   checks   = 0;
   int   failures = 0;
   int   pushed   = 0;
   int   done     = 0;
   exp_t expq [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge Clock_pin);
      #1;
   endtask

   // reference: bytes from first non-zero down to byte 0, then optional CR LF
   task automatic expect_string(input logic [95:0] s);
      bit   started;
      int   added;
      exp_t e;
      started = 0;
      added   = 0;
      for (int i = 11; i >= 0; i--) begin
         if (s[i*8 +: 8] != 8'h00) started = 1;
         if (started) begin
            expq.push_back({s[i*8 +: 8], 1'b0});
            added++;
         end
      end
      if (TERM == 2) begin
         expq.push_back({8'h0D, 1'b0});
         expq.push_back({8'h0A, 1'b0});
         added += 2;
      end
      if (added > 0) begin
         e = expq.pop_back();
         e.last = 1'b1;
         expq.push_back(e);
         pushed++;
      end
   endtask

   function automatic logic [95:0] rand_str(input int nz);
      logic [95:0] s;
      logic [7:0]  b;
      s = '0;
      for (int i = 11; i >= 0; i--) begin
         if (11 - i < nz)       b = 8'h00;
         else if (11 - i == nz) b = 8'($urandom_range(1, 255));
         else                   b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         s[i*8 +: 8] = b;
      end
      return s;
   endfunction

   function automatic logic [95:0] full_str();
      logic [95:0] s;
      for (int i = 0; i < 12; i++) s[i*8 +: 8] = 8'($urandom_range(1, 255));
      return s;
   endfunction

   task automatic strobe(input logic [95:0] s, input bit accept);
      trace.ICis       = s;
      trace.ICis_valid = 1'b1;
      if (accept) expect_string(s);
      tick();
      trace.ICis_valid = 1'b0;
   endtask

   // cycles after the strobe cycle until out_valid is first seen
   task automatic valid_lat(output int lat);
      lat = 0;
      do begin
         @(negedge Clock_pin);
         lat++;
      end while (!trace.out_valid && lat < 40);
   endtask

   task automatic busy_lat(output int lat);
      lat = 0;
      do begin
         @(negedge Clock_pin);
         lat++;
      end while (busy && lat < 60);
   endtask

   task automatic wait_drain(input string name, input int bound);
      int n;
      n = 0;
      while (expq.size() != 0 && n < bound) begin
         @(negedge Clock_pin);
         #2;
         n++;
      end
      chk(name, 32'(expq.size()), 32'd0);
      @(negedge Clock_pin);
      chk({name, "_busy"}, 32'(busy), 32'd0);
      @(posedge Clock_pin);
      #1;
   endtask

   // monitor: compare every handshake against the queue, and check stability while stalled
   bit         hold_pending = 0;
   logic [7:0] held;
   initial begin
      exp_t e;
      forever begin
         @(negedge Clock_pin);
         if (Reset_pin) begin
            hold_pending = 0;
         end else begin
            if (hold_pending) begin
               chk("hold_valid", 32'(trace.out_valid), 32'd1);
               chk("hold_data", 32'(trace.out_data), 32'(held));
            end
            if (trace.out_valid && trace.out_ready) begin
               if (expq.size() == 0) begin
                  chk("unexpected_byte", 32'(trace.out_data), 32'hFFFF_FFFF);
               end else begin
                  e = expq.pop_front();
                  chk("byte", 32'(trace.out_data), 32'(e.b));
                  if (e.last) done++;
               end
            end
            hold_pending = trace.out_valid && !trace.out_ready;
            held         = trace.out_data;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [95:0] s;
      int          lat;
      int          left;
      int          guard;

      Reset_pin        = 1'b1;
      trace.ICis       = '0;
      trace.ICis_valid = 1'b0;
      trace.out_ready  = 1'b1;
      repeat (3) tick();
      Reset_pin = 1'b0;
      chk("rst_valid", 32'(trace.out_valid), 32'd0);
      chk("rst_data", 32'(trace.out_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      tick();

      // eight leading NULs then "RST "
      strobe({64'h0, 32'h5253_5420}, 1);
      valid_lat(lat);
      chk("rst_str_lat", 32'(lat), 32'd10);
      chk("rst_str_first", 32'(trace.out_data), 32'h52);
      tick();
      wait_drain("rst_str_drain", 100);

      // full string "ADD  R1, R2;"
      strobe(96'h4144_4420_2052_312C_2052_323B, 1);
      valid_lat(lat);
      chk("add_lat", 32'(lat), 32'd2);
      chk("add_first", 32'(trace.out_data), 32'h41);
      tick();
      wait_drain("add_drain", 100);

      // stall for five cycles mid-string
      trace.out_ready = 1'b0;
      s = full_str();
      strobe(s, 1);
      valid_lat(lat);
      chk("hold_lat", 32'(lat), 32'd2);
      tick();
      trace.out_ready = 1'b1;
      repeat (3) tick();
      trace.out_ready = 1'b0;
      @(negedge Clock_pin);
      held = trace.out_data;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clock_pin);
         chk("stall_data", 32'(trace.out_data), 32'(held));
         chk("stall_valid", 32'(trace.out_valid), 32'd1);
      end
      tick();
      trace.out_ready = 1'b1;
      wait_drain("hold_drain", 100);

      // all-zero string: 12 skip cycles, only terminator (if any)
      strobe(96'h0, 1);
      busy_lat(lat);
      chk("zero_busy_lat", 32'(lat), 32'(14 + TERM));
      tick();
      wait_drain("zero_drain", 50);

      // randomized strings with random backpressure, never overfilling the FIFO
      left  = 40;
      guard = 0;
      while (left > 0 && guard < 6000) begin
         trace.out_ready = ($urandom_range(0, 3) != 0);
         if ((pushed - done) < DEPTH && $urandom_range(0, 2) == 0) begin
            strobe(rand_str($urandom_range(0, 11)), 1);
            left--;
         end else begin
            tick();
         end
         guard++;
      end
      chk("rand_issued", 32'(left), 32'd0);
      trace.out_ready = 1'b1;
      wait_drain("rand_drain", 3000);
      chk("rand_drop", 32'(drop_cnt), 32'd0);
      chk("rand_overflow", 32'(overflow), 32'd0);

      // DEPTH+3 back-to-back strobes with sink stalled: DEPTH+1 accepted
      trace.out_ready = 1'b0;
      for (int k = 0; k < DEPTH + 3; k++) begin
         s = (k == 0) ? full_str() : rand_str($urandom_range(0, 11));
         strobe(s, k < DEPTH + 1);
      end
      chk("ovf_drop", 32'(drop_cnt), 32'd2);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_busy", 32'(busy), 32'd1);
      // release sink: head string finishes after 12+TERM handshakes, then IDLE, then LOAD
      trace.out_ready = 1'b1;
      repeat (12 + TERM) tick();
      tick();
      strobe(rand_str($urandom_range(0, 11)), 1);
      chk("fullpop_nodrop", 32'(drop_cnt), 32'd2);
      wait_drain("ovf_drain", 400);

      // saturation of the drop counter
      trace.out_ready = 1'b0;
      for (int k = 0; k < 300; k++) begin
         strobe(rand_str($urandom_range(0, 11)), k < DEPTH + 1);
         if (k == 108) chk("sat_mid", 32'(drop_cnt), 32'd102);
      end
      chk("sat_drop", 32'(drop_cnt), 32'd255);
      chk("sat_flag", 32'(overflow), 32'd1);
      trace.out_ready = 1'b1;
      wait_drain("sat_drain", 400);

      // reset while sending byte 6 (five bytes already out); strobe during reset ignored
      trace.out_ready = 1'b0;
      strobe(full_str(), 1);
      valid_lat(lat);
      chk("mid_lat", 32'(lat), 32'd2);
      tick();
      trace.out_ready = 1'b1;
      repeat (5) tick();
      trace.out_ready  = 1'b0;
      Reset_pin        = 1'b1;
      trace.ICis       = full_str();
      trace.ICis_valid = 1'b1;
      tick();
      Reset_pin        = 1'b0;
      trace.ICis_valid = 1'b0;
      expq.delete();
      done = pushed;
      chk("mid_rst_valid", 32'(trace.out_valid), 32'd0);
      chk("mid_rst_data", 32'(trace.out_data), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_overflow", 32'(overflow), 32'd0);
      chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
      tick();
      chk("rst_strobe_ignored", 32'(busy), 32'd0);

      // fresh string streams normally from byte 11
      trace.out_ready = 1'b1;
      s = full_str();
      strobe(s, 1);
      valid_lat(lat);
      chk("post_rst_lat", 32'(lat), 32'd2);
      chk("post_rst_first", 32'(trace.out_data), 32'(s[95:88]));
      tick();
      wait_drain("post_rst_drain", 100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
